// File: rtl/ex_alu_pkg.sv
// ============================================================================
// Module      : ex_alu_pkg
// Description : Shared types and helpers for the EX-stage ALU. Defines the
//               operation encoding seen on in_op, the adder16 mode encoding,
//               and the op -> adder-mode mapping used by ex_alu_stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_alu_pkg;

  typedef enum logic [2:0] {
    ADD   = 3'b000,
    SUB   = 3'b001,
    PADDW = 3'b010,
    PADDS = 3'b011,
    MOVB  = 3'b100,
    SLT   = 3'b101,
    RSV6  = 3'b110,
    RSV7  = 3'b111
  } alu_op_e;

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_SUB   = 2'b01;
  localparam logic [1:0] MODE_PADDW = 2'b10;
  localparam logic [1:0] MODE_PADDS = 2'b11;

  // SLT reuses the subtractor; ops that ignore the adder default to ADD.
  function automatic logic [1:0] op_to_mode(input alu_op_e op);
    logic [1:0] mode;
    mode = MODE_ADD;
    case (op)
      ADD:     mode = MODE_ADD;
      SUB:     mode = MODE_SUB;
      PADDW:   mode = MODE_PADDW;
      PADDS:   mode = MODE_PADDS;
      SLT:     mode = MODE_SUB;
      default: mode = MODE_ADD;
    endcase
    return mode;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder16.sv
// ============================================================================
// Module      : adder16
// Description : 16-bit signed adder with four modes:
//                 00 saturating add, 01 saturating subtract,
//                 10 wrapping nibble add, 11 saturating nibble add.
// Ports       : a, b   - signed operands
//               mode   - operating mode (see above)
//               sum    - result
//               cout   - carry out of each nibble (chained in full modes,
//                        independent in nibble modes)
//               ov     - signed overflow (full modes: 16-bit overflow;
//                        nibble modes: OR of the four nibble overflows)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder16
  import ex_alu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  mode,
  output logic [15:0] sum,
  output logic [3:0]  cout,
  output logic        ov
);

  logic [15:0] w_b_eff;
  logic [15:0] w_raw;
  logic [15:0] w_nib_sum;
  logic [3:0]  w_nib_ov;
  logic [3:0]  w_cout;
  logic        w_carry;
  logic [4:0]  w_nib;

  // Subtraction is a + ~b + 1; the +1 enters as carry-in of nibble 0.
  assign w_b_eff = (mode == MODE_SUB) ? ~b : b;

  always_comb begin
    w_raw     = '0;
    w_nib_sum = '0;
    w_nib_ov  = '0;
    w_cout    = '0;
    w_nib     = '0;
    w_carry   = (mode == MODE_SUB);
    for (int i = 0; i < 4; i++) begin
      // Nibble modes break the carry chain at every nibble boundary.
      w_nib = {1'b0, a[4*i +: 4]} + {1'b0, w_b_eff[4*i +: 4]}
            + {4'b0000, (mode[1] ? 1'b0 : w_carry)};
      w_raw[4*i +: 4] = w_nib[3:0];
      w_cout[i]       = w_nib[4];
      w_carry         = w_nib[4];
      w_nib_ov[i]     = (a[4*i+3] == w_b_eff[4*i+3]) && (w_nib[3] != a[4*i+3]);
      if ((mode == MODE_PADDS) && w_nib_ov[i])
        w_nib_sum[4*i +: 4] = a[4*i+3] ? 4'h8 : 4'h7;
      else
        w_nib_sum[4*i +: 4] = w_nib[3:0];
    end
  end

  always_comb begin
    cout = w_cout;
    if (mode[1]) begin
      ov  = |w_nib_ov;
      sum = w_nib_sum;
    end else begin
      // Top-nibble overflow is the 16-bit signed overflow.
      ov  = w_nib_ov[3];
      sum = w_nib_ov[3] ? (a[15] ? 16'h8000 : 16'h7FFF) : w_raw;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_alu_stage.sv
// ============================================================================
// Module      : ex_alu_stage
// Description : Execute stage of the 5-stage pipeline. Runs ID/EX operands
//               through a single adder16 and registers result, carries and
//               overflow into EX/MEM behind a valid/ready handshake, with a
//               branch-squash flush and a sticky overflow status bit.
// Ports       : clk, rst                - clock, async active-high reset
//               in_valid/in_ready       - upstream handshake
//               in_op,in_a,in_b,in_rd,in_we - decoded ID/EX entry
//               flush                   - squash in-flight and incoming entry
//               out_valid/out_ready     - downstream handshake
//               out_result,out_cout,out_ov,out_rd,out_we - EX/MEM entry
//               sticky_ov, ov_clr       - overflow status and its clear
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_alu_stage
  import ex_alu_pkg::*;
#(
  parameter int RDW = 3,
  parameter int W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_op,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [RDW-1:0] in_rd,
  input  logic           in_we,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_result,
  output logic [3:0]     out_cout,
  output logic           out_ov,
  output logic [RDW-1:0] out_rd,
  output logic           out_we,
  output logic           sticky_ov,
  input  logic           ov_clr
);

  if (W != 16) begin : g_width_check
    $error("ex_alu_stage: W must be 16 to match adder16");
  end

  alu_op_e        w_op;
  logic [1:0]     w_mode;
  logic [15:0]    w_sum;
  logic [3:0]     w_cout;
  logic           w_ov;
  logic           w_accept;
  logic           w_adder_op;

  logic [W-1:0]   w_result;
  logic [3:0]     w_res_cout;
  logic           w_res_ov;
  logic           w_res_we;

  logic           valid_q,  valid_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     cout_q,   cout_d;
  logic           ov_q,     ov_d;
  logic [RDW-1:0] rd_q,     rd_d;
  logic           we_q,     we_d;
  logic           sticky_q, sticky_d;

  assign w_op       = alu_op_e'(in_op);
  assign w_mode     = op_to_mode(w_op);
  assign w_adder_op = (in_op[2] == 1'b0);

  adder16 u_adder16 (
    .a    (in_a),
    .b    (in_b),
    .mode (w_mode),
    .sum  (w_sum),
    .cout (w_cout),
    .ov   (w_ov)
  );

  assign in_ready = !valid_q || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  // Result selection for the incoming entry.
  always_comb begin
    w_result   = '0;
    w_res_cout = '0;
    w_res_ov   = 1'b0;
    w_res_we   = in_we;
    case (w_op)
      ADD, SUB, PADDW, PADDS: begin
        w_result   = w_sum;
        w_res_cout = w_cout;
        w_res_ov   = w_ov;
      end
      MOVB: w_result = in_b;
      // Saturation preserves sign, so the saturated difference's MSB is a<b.
      SLT:  w_result = {{(W-1){1'b0}}, w_sum[15]};
      default: w_res_we = 1'b0;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    cout_d   = cout_q;
    ov_d     = ov_q;
    rd_d     = rd_q;
    we_d     = we_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d  = 1'b1;
      result_d = w_result;
      cout_d   = w_res_cout;
      ov_d     = w_res_ov;
      rd_d     = in_rd;
      we_d     = w_res_we;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Set is evaluated after clear so a simultaneous set wins.
  always_comb begin
    sticky_d = sticky_q;
    if (ov_clr)
      sticky_d = 1'b0;
    if (w_accept && w_adder_op && w_ov)
      sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= '0;
      ov_q     <= 1'b0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ov_q     <= ov_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_cout   = cout_q;
  assign out_ov     = ov_q;
  assign out_rd     = rd_q;
  assign out_we     = we_q;
  assign sticky_ov  = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_stage.sv
// ============================================================================
// Module      : tb_ex_alu_stage
// Description : Self-checking bench for ex_alu_stage. A table of directed
//               vectors with hand-computed results, plus hand-written
//               sequences for sticky clear, backpressure, flush and
//               asynchronous reset.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'b000;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [2:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [3:0]  out_cout;
  logic        out_ov;
  logic [2:0]  out_rd;
  logic        out_we;
  logic        sticky_ov;
  logic        ov_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_alu_stage #(.RDW(3), .W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_ov     (out_ov),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .sticky_ov  (sticky_ov),
    .ov_clr     (ov_clr)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
    logic [15:0] res;
    logic [3:0]  cout;
    logic        ov;
    logic        ewe;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] rd, input logic we);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    in_we    = we;
  endtask

  initial begin
    //              op      a        b        we    res      cout  ov    ewe
    vecs[0]  = '{3'b000, 16'h7000, 16'h2000, 1'b1, 16'h7FFF, 4'h0, 1'b1, 1'b1};
    vecs[1]  = '{3'b001, 16'h8000, 16'h0001, 1'b1, 16'h8000, 4'h8, 1'b1, 1'b1};
    vecs[2]  = '{3'b101, 16'hFFFB, 16'h0003, 1'b1, 16'h0001, 4'h0, 1'b0, 1'b1};
    vecs[3]  = '{3'b010, 16'h7777, 16'h1111, 1'b1, 16'h8888, 4'h0, 1'b1, 1'b1};
    vecs[4]  = '{3'b011, 16'h7777, 16'h1111, 1'b1, 16'h7777, 4'h0, 1'b1, 1'b1};
    vecs[5]  = '{3'b110, 16'h1234, 16'h4321, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 16'hAAAA, 16'h1234, 1'b1, 16'h1234, 4'h0, 1'b0, 1'b1};
    vecs[7]  = '{3'b000, 16'h0001, 16'h0002, 1'b0, 16'h0003, 4'h0, 1'b0, 1'b0};
    vecs[8]  = '{3'b001, 16'h0005, 16'h0003, 1'b1, 16'h0002, 4'hF, 1'b0, 1'b1};
    vecs[9]  = '{3'b000, 16'h8000, 16'h8000, 1'b1, 16'h8000, 4'h8, 1'b1, 1'b1};
    vecs[10] = '{3'b011, 16'h8888, 16'hFFFF, 1'b1, 16'h8888, 4'hF, 1'b1, 1'b1};
    vecs[11] = '{3'b010, 16'h0F0F, 16'h0101, 1'b1, 16'h0000, 4'h5, 1'b0, 1'b1};
    vecs[12] = '{3'b101, 16'h0003, 16'hFFFB, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b1};
    vecs[13] = '{3'b111, 16'h0001, 16'h0001, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0};

    // ---------------- reset state ----------------
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_result", {16'b0, out_result}, 32'h0);
    check("rst_sticky", {31'b0, sticky_ov}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // ---------------- table: back-to-back, ov_clr held so each vector
    // shows only its own sticky contribution (set beats clear) ----------
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 3'(i), vecs[i].we);
      ov_clr = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'h1);
      check($sformatf("v%0d_result", i), {16'b0, out_result}, {16'b0, vecs[i].res});
      check($sformatf("v%0d_cout", i), {28'b0, out_cout}, {28'b0, vecs[i].cout});
      check($sformatf("v%0d_ov", i), {31'b0, out_ov}, {31'b0, vecs[i].ov});
      check($sformatf("v%0d_rd", i), {29'b0, out_rd}, {29'b0, 3'(i)});
      check($sformatf("v%0d_we", i), {31'b0, out_we}, {31'b0, vecs[i].ewe});
      check($sformatf("v%0d_sticky", i), {31'b0, sticky_ov},
            {31'b0, (vecs[i].op[2] == 1'b0) && vecs[i].ov});
    end
    @(negedge clk);
    in_valid = 1'b0;
    ov_clr = 1'b0;

    // ---------------- sticky set then clear ----------------
    @(negedge clk);
    drive(3'b000, 16'h7000, 16'h2000, 3'd1, 1'b1);
    @(posedge clk);
    #1;
    check("stk_set", {31'b0, sticky_ov}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    ov_clr = 1'b1;
    @(posedge clk);
    #1;
    check("stk_clr", {31'b0, sticky_ov}, 32'h0);
    check("retire_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    ov_clr = 1'b0;
    @(posedge clk);
    #1;
    check("stk_stays_clr", {31'b0, sticky_ov}, 32'h0);

    // ---------------- backpressure ----------------
    @(negedge clk);
    drive(3'b000, 16'h0001, 16'h0002, 3'd2, 1'b1);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("bp_valid", {31'b0, out_valid}, 32'h1);
    check("bp_result", {16'b0, out_result}, 32'h3);
    @(negedge clk);
    drive(3'b100, 16'h0000, 16'h1234, 3'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_result", k), {16'b0, out_result}, 32'h3);
      check($sformatf("bp_hold%0d_rd", k), {29'b0, out_rd}, 32'h2);
      check($sformatf("bp_hold%0d_in_ready", k), {31'b0, in_ready}, 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("bp_b2b_valid", {31'b0, out_valid}, 32'h1);
    check("bp_b2b_result", {16'b0, out_result}, 32'h1234);
    check("bp_b2b_rd", {29'b0, out_rd}, 32'h3);

    // ---------------- flush beats both accept and hold ----------------
    @(negedge clk);
    drive(3'b000, 16'h7FFF, 16'h0001, 3'd4, 1'b1);
    out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    check("flush_sticky", {31'b0, sticky_ov}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("flush_idle_valid", {31'b0, out_valid}, 32'h0);

    // ---------------- async reset mid-cycle ----------------
    @(negedge clk);
    drive(3'b000, 16'h7000, 16'h2000, 3'd5, 1'b1);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("ar_pre_valid", {31'b0, out_valid}, 32'h1);
    check("ar_pre_sticky", {31'b0, sticky_ov}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'h0);
    check("ar_sticky", {31'b0, sticky_ov}, 32'h0);
    check("ar_result", {16'b0, out_result}, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ar_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("ar_post_valid", {31'b0, out_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
